jk_bank_sequencer: RTL

- Command-driven controller for a bank of `WIDTH` JK flip-flops.
- Each accepted command is translated into per-bit J/K drive patterns, applied for a programmed number of clock cycles:
  - set, clear and toggle on masked bits;
  - synchronous up/down counting using JK toggle equations.
- Sits between a register/bus front end (valid/ready command port) and the JK storage bank it owns.
- Reports completion with a one-cycle `done` pulse.

---
 rtl/jk_seq_pkg.sv | 49 ++++
 rtl/jk_cell.sv | 33 +++
 rtl/jk_bank_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/jk_seq_pkg.sv
// jk_seq_pkg: shared types and helpers for the JK bank sequencer.
//   op_e      : command op codes (6 and 7 are reserved, executed as HOLD)
//   state_e   : sequencer FSM states
//   JK_*      : {j,k} drive patterns for a single cell
//   jk_pattern: per-bit {j,k} for an op given that bit's count toggle terms
//   is_reserved: true for op codes that must raise err on completion
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_CNT_UP = 3'd4,
    OP_CNT_DN = 3'd5,
    OP_RSVD6  = 3'd6,
    OP_RSVD7  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // up_t / dn_t: AND of all lower q bits (resp. all lower ~q bits); 1 for bit 0.
  function automatic logic [1:0] jk_pattern(input op_e op, input logic up_t,
                                            input logic dn_t);
    logic [1:0] pat;
    case (op)
      OP_CLEAR:  pat = JK_RST;
      OP_SET:    pat = JK_SET;
      OP_TOGGLE: pat = JK_TGL;
      OP_CNT_UP: pat = up_t ? JK_TGL : JK_HOLD;
      OP_CNT_DN: pat = dn_t ? JK_TGL : JK_HOLD;
      default:   pat = JK_HOLD;
    endcase
    return pat;
  endfunction

  function automatic logic is_reserved(input op_e op);
    return (op == OP_RSVD6) || (op == OP_RSVD7);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop with synchronous active-high reset.
//   clk   : clock, rising edge
//   reset : synchronous clear to 0, overrides j/k
//   j, k  : 00 hold, 01 clear, 10 set, 11 toggle
//   q     : stored bit
//   qnot  : complement of q
module jk_cell
  import jk_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qnot
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_RST:  q <= 1'b0;
        JK_SET:  q <= 1'b1;
        JK_TGL:  q <= ~q;
        default: q <= q;
      endcase
    end
  end

  assign qnot = ~q;

endmodule

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven controller for a bank of WIDTH JK cells.
// An accepted command drives its J/K pattern into the masked bits for
// cmd_count+1 consecutive cycles, then pulses done (and err for reserved ops).
//   clk, reset : clock and synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake; cmd_op/cmd_mask/cmd_count latched on accept
//   abort      : cancels a running command without applying on that edge
//   q          : bank state
//   busy       : command executing
//   done, err  : one-cycle completion pulses (err only for reserved ops)
module jk_bank_sequencer
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e           state;
  op_e              op_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] rem;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic [WIDTH-1:0] qnot;

  // Held low during reset so no command is offered while the bank clears.
  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign busy      = (state == ST_RUN);

  // Carry/borrow chains run over every bit's current q regardless of mask,
  // so masked-off bits hold but still gate the toggles above them.
  always_comb begin
    logic up_t;
    logic dn_t;
    j_vec = '0;
    k_vec = '0;
    up_t  = 1'b1;
    dn_t  = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ((state == ST_RUN) && !abort && mask_q[i]) begin
        {j_vec[i], k_vec[i]} = jk_pattern(op_q, up_t, dn_t);
      end
      up_t = up_t & q[i];
      dn_t = dn_t & qnot[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      op_q   <= OP_HOLD;
      mask_q <= '0;
      rem    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q   <= op_e'(cmd_op);
            mask_q <= cmd_mask;
            rem    <= cmd_count;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (rem == '0) begin
            state <= ST_IDLE;
            done  <= 1'b1;
            err   <= is_reserved(op_q);
          end else begin
            rem <= rem - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (j_vec[g]),
      .k    (k_vec[g]),
      .q    (q[g]),
      .qnot (qnot[g])
    );
  end

endmodule
